axi3_rd_arbiter: RTL and testbench
==================================

// Module: axi3_rd_arbiter
// PURPOSE
//   Shares one AXI3 read port (AR + R channels) among N_MASTER cache-side read clients:
//   icache = ID 0, dcache = ID 1, dcache_pass = ID 2.
//   Round-robin arbitration on AR; ARID is driven with the granted master index.
//   R beats are routed back by RID. Per-master outstanding limit.
//   Sits between the cache/uncached-buffer blocks and the AXI3 read interface of the memory/bus.
// PARAMETERS
//   N_MASTER    3   number of read clients (ID = client index)
//   ID_WIDTH    4   AXI ARID/RID width (> clog2(N_MASTER))
//   ADDR_WIDTH  32  AXI address width
//   DATA_WIDTH  32  AXI data width
//   MAX_OUTST   2   max outstanding bursts per master (>= 1)
// PORTS
//   clk            in   1              clock
//   rst_n          in   1              async active-low reset
//   m_arvalid      in   N_MASTER       per-master AR valid
//   m_araddr       in   N*ADDR_WIDTH   per-master address, packed; master i at [i*AW +: AW]
//   m_arlen        in   N*4            per-master burst length - 1
//   m_arsize       in   N*3            per-master beat size
//   m_arburst      in   N*2            per-master burst type
//   m_arready      out  N_MASTER       per-master AR accept
//   m_rvalid       out  N_MASTER       R beat valid to master RID
//   m_rdata        out  DATA_WIDTH     R data, broadcast
//   m_rresp        out  2              R resp, broadcast
//   m_rlast        out  1              R last, broadcast
//   m_rready       in   N_MASTER       per-master R ready
//   s_arid         out  ID_WIDTH       granted master index, zero-extended
//   s_araddr/s_arlen/s_arsize/s_arburst  out  AW/4/3/2  registered AR payload
//   s_arvalid      out  1              AR valid to slave
//   s_arready      in   1              AR ready from slave
//   s_rid          in   ID_WIDTH       R id
//   s_rdata        in   DATA_WIDTH     R data
//   s_rresp        in   2              R resp
//   s_rlast        in   1              R last
//   s_rvalid       in   1              R valid
//   s_rready       out  1              R ready to slave
//   err_unk_id     out  1              one-cycle pulse per R beat with RID >= N_MASTER
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state = IDLE; s_arvalid = 0; all s_ar* payload = 0; err_unk_id = 0.
//     - All outstanding counters = 0; rr pointer last = N_MASTER-1, so master 0 has first priority.
//   FSM IDLE:
//     - eligible[i] = m_arvalid[i] & (outst[i] != MAX_OUTST).
//     - Winner = first eligible index after last, wrapping.
//     - m_arready[winner] = 1 combinationally; all other m_arready = 0.
//     - On winner: capture payload, set s_arid = winner, update last = winner, go to ADDR.
//     - No eligible master: stay in IDLE.
//   FSM ADDR:
//     - s_arvalid = 1; all m_arready = 0; payload held stable.
//     - On s_arready: go to IDLE. No new grant in that cycle.
//     - Result: one AR per >= 2 cycles; master-to-slave AR latency is 1 cycle.
//   Counters:
//     - outst[i] += 1 on the ADDR-state handshake for ID i.
//     - outst[i] -= 1 on an R handshake with s_rlast for RID i.
//     - Both in the same cycle for the same i: unchanged.
//     - Never exceeds MAX_OUTST. Never underflows; a dec at 0 is ignored.
//   R routing (combinational, zero latency):
//     - m_rvalid[i] = s_rvalid & (s_rid == i).
//     - s_rready = m_rready[s_rid] when s_rid < N_MASTER, else 1.
//     - Beats with an unknown RID are drained and dropped.
//     - err_unk_id is registered: a pulse 1 cycle after each such handshake.
//   Ordering: R beats may interleave across IDs; within one ID, order is the slave's order.
//   Reset mid-burst: everything returns to reset values at once; in-flight R beats after
//   release are still routed by RID.
// TESTING
//   T1: assert and release rst_n -> s_arvalid = 0, m_arready = 0, err_unk_id = 0, outst all 0.
//   T2: m0 reads 0x1000 with arlen 3; slave returns 4 beats with RID 0 and rlast on beat 4
//       -> s_arid = 0, s_araddr = 0x1000; m_rvalid[0] on 4 beats only; m_rvalid[2:1] stay 0.
//   T3: m0, m1 and m2 request together and stay asserted, slave always ready
//       -> grant order 0,1,2,0. Each request is accepted 2 cycles after the previous one.
//   T4: MAX_OUTST = 2; m1 issues 3 ARs with no R returned -> 3rd held, m_arready[1] stays 0;
//       after one rlast with RID 1 the 3rd AR is accepted.
//   T5: R beat with s_rid = 5 -> s_rready = 1, no m_rvalid, err_unk_id high for exactly 1 cycle.
//   T6: rst_n low while in ADDR with s_arready = 0 -> s_arvalid drops asynchronously;
//       after release, m0 has first priority.

Source files
------------

// File: rtl/axi3_rd_arbiter.sv
// rtl/axi3_rd_arbiter.sv - round-robin AXI3 read arbiter with RID-based R routing
// Grants one AR per two cycles at most and caps outstanding bursts per master.
module axi3_rd_arbiter #(
    parameter int N_MASTER   = 3,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            m_arvalid,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
    input  logic [N_MASTER*4-1:0]          m_arlen,
    input  logic [N_MASTER*3-1:0]          m_arsize,
    input  logic [N_MASTER*2-1:0]          m_arburst,
    output logic [N_MASTER-1:0]            m_arready,
    output logic [N_MASTER-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rlast,
    input  logic [N_MASTER-1:0]            m_rready,
    output logic [ID_WIDTH-1:0]            s_arid,
    output logic [ADDR_WIDTH-1:0]          s_araddr,
    output logic [3:0]                     s_arlen,
    output logic [2:0]                     s_arsize,
    output logic [1:0]                     s_arburst,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    input  logic [ID_WIDTH-1:0]            s_rid,
    input  logic [DATA_WIDTH-1:0]          s_rdata,
    input  logic [1:0]                     s_rresp,
    input  logic                           s_rlast,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    output logic                           err_unk_id
);

    localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} state_t;

    state_t                  state_q;
    logic [IW-1:0]           last_q;
    logic [CW-1:0]           outst_q [N_MASTER];
    logic [ID_WIDTH-1:0]     s_arid_q;
    logic [ADDR_WIDTH-1:0]   s_araddr_q;
    logic [3:0]              s_arlen_q;
    logic [2:0]              s_arsize_q;
    logic [1:0]              s_arburst_q;
    logic                    err_unk_id_q;

    logic                    grant_found;
    logic [IW-1:0]           grant_idx;
    logic [N_MASTER-1:0]     eligible;
    logic                    rid_known;
    logic                    r_hs;

    // Search starts one past the last winner so every client gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            eligible[i] = m_arvalid[i] & (outst_q[i] != CW'(MAX_OUTST));
        end
        for (int k = 1; k <= N_MASTER; k++) begin
            int idx;
            idx = (int'(last_q) + k) % N_MASTER;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        m_arready = '0;
        if (state_q == IDLE && grant_found) begin
            m_arready[grant_idx] = 1'b1;
        end
    end

    assign rid_known = (s_rid < ID_WIDTH'(N_MASTER));
    assign s_rready  = rid_known ? m_rready[s_rid[IW-1:0]] : 1'b1;
    assign r_hs      = s_rvalid & s_rready;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;

    always_comb begin
        for (int i = 0; i < N_MASTER; i++) begin
            m_rvalid[i] = s_rvalid & (s_rid == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IW'(N_MASTER - 1);
            s_arid_q     <= '0;
            s_araddr_q   <= '0;
            s_arlen_q    <= '0;
            s_arsize_q   <= '0;
            s_arburst_q  <= '0;
            err_unk_id_q <= 1'b0;
        end else begin
            err_unk_id_q <= r_hs & ~rid_known;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        state_q     <= ADDR;
                        last_q      <= grant_idx;
                        s_arid_q    <= {{(ID_WIDTH-IW){1'b0}}, grant_idx};
                        s_araddr_q  <= m_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        s_arlen_q   <= m_arlen[grant_idx*4 +: 4];
                        s_arsize_q  <= m_arsize[grant_idx*3 +: 3];
                        s_arburst_q <= m_arburst[grant_idx*2 +: 2];
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Issue and completion for the same ID in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MASTER; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTER; i++) begin
                logic inc, dec;
                inc = (state_q == ADDR) & s_arready & (s_arid_q == ID_WIDTH'(i));
                dec = r_hs & s_rlast & (s_rid == ID_WIDTH'(i)) & (outst_q[i] != '0);
                if (inc && !dec) begin
                    outst_q[i] <= outst_q[i] + 1'b1;
                end else if (dec && !inc) begin
                    outst_q[i] <= outst_q[i] - 1'b1;
                end
            end
        end
    end

    assign s_arvalid  = (state_q == ADDR);
    assign s_arid     = s_arid_q;
    assign s_araddr   = s_araddr_q;
    assign s_arlen    = s_arlen_q;
    assign s_arsize   = s_arsize_q;
    assign s_arburst  = s_arburst_q;
    assign err_unk_id = err_unk_id_q;

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb/tb_axi3_rd_arbiter.sv - self-checking bench for axi3_rd_arbiter
module tb_axi3_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_arvalid;
    logic [95:0] m_araddr;
    logic [11:0] m_arlen;
    logic [8:0]  m_arsize;
    logic [5:0]  m_arburst;
    logic [2:0]  m_arready;
    logic [2:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [2:0]  m_rready;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [3:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic        err_unk_id;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi3_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rready(m_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .err_unk_id(err_unk_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_rready = '0; s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clr_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       rv;
        logic [3:0] rid;
        logic [2:0] rr;
        logic [2:0] exp_mrv;
        logic       exp_srr;
    } rvec_t;

    rvec_t vecs[9];

    int          md_outst[3];
    int          md_last;
    bit          md_busy;
    int          md_id;
    logic [31:0] md_addr;
    logic [3:0]  md_len;
    bit          md_err;

    initial begin
        int g_id[8];
        int g_cyc[8];
        int ng, cnt, bad;

        vecs[0] = '{1'b1, 4'd0,  3'b001, 3'b001, 1'b1};
        vecs[1] = '{1'b1, 4'd0,  3'b110, 3'b001, 1'b0};
        vecs[2] = '{1'b1, 4'd1,  3'b010, 3'b010, 1'b1};
        vecs[3] = '{1'b1, 4'd2,  3'b011, 3'b100, 1'b0};
        vecs[4] = '{1'b1, 4'd2,  3'b100, 3'b100, 1'b1};
        vecs[5] = '{1'b1, 4'd3,  3'b000, 3'b000, 1'b1};
        vecs[6] = '{1'b1, 4'd15, 3'b000, 3'b000, 1'b1};
        vecs[7] = '{1'b0, 4'd1,  3'b111, 3'b000, 1'b1};
        vecs[8] = '{1'b0, 4'd2,  3'b000, 3'b000, 1'b0};

        rst_n = 1'b1;
        clr_inputs();

        // T1: reset state
        do_reset();
        @(negedge clk);
        chk("t1_arvalid", 64'(s_arvalid), 64'd0);
        chk("t1_arready", 64'(m_arready), 64'd0);
        chk("t1_err", 64'(err_unk_id), 64'd0);
        chk("t1_araddr", 64'(s_araddr), 64'd0);

        // R routing table
        step();
        for (int v = 0; v < 9; v++) begin
            s_rvalid = vecs[v].rv; s_rid = vecs[v].rid; m_rready = vecs[v].rr;
            #1;
            chk($sformatf("tab%0d_mrvalid", v), 64'(m_rvalid), 64'(vecs[v].exp_mrv));
            chk($sformatf("tab%0d_srready", v), 64'(s_rready), 64'(vecs[v].exp_srr));
        end
        s_rvalid = 1'b0;

        // T2: single burst for m0
        do_reset();
        m_arvalid = 3'b001; m_araddr[31:0] = 32'h1000; m_arlen[3:0] = 4'd3;
        @(negedge clk);
        chk("t2_grant", 64'(m_arready), 64'b001);
        step();
        m_arvalid = '0; s_arready = 1'b1;
        @(negedge clk);
        chk("t2_arvalid", 64'(s_arvalid), 64'd1);
        chk("t2_arid", 64'(s_arid), 64'd0);
        chk("t2_araddr", 64'(s_araddr), 64'h1000);
        chk("t2_arlen", 64'(s_arlen), 64'd3);
        step();
        s_arready = 1'b0; m_rready = 3'b001;
        cnt = 0; bad = 0;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1; s_rid = 4'd0; s_rlast = (b == 3); s_rdata = 32'(b);
            @(negedge clk);
            if (m_rvalid == 3'b001) cnt++;
            if (m_rvalid[2:1] != 2'b00) bad++;
            step();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        chk("t2_beats", 64'(cnt), 64'd4);
        chk("t2_other", 64'(bad), 64'd0);
        chk("t2_idle_rvalid", 64'(m_rvalid), 64'd0);

        // T3: round robin with all masters requesting
        do_reset();
        m_arvalid = 3'b111; s_arready = 1'b1;
        ng = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (m_arready[i] && ng < 8) begin
                    g_id[ng] = i; g_cyc[ng] = c; ng++;
                end
            end
            step();
        end
        chk("t3_ngrants", 64'(ng >= 4), 64'd1);
        if (ng >= 4) begin
            chk("t3_g0", 64'(g_id[0]), 64'd0);
            chk("t3_g1", 64'(g_id[1]), 64'd1);
            chk("t3_g2", 64'(g_id[2]), 64'd2);
            chk("t3_g3", 64'(g_id[3]), 64'd0);
            chk("t3_gap1", 64'(g_cyc[1] - g_cyc[0]), 64'd2);
            chk("t3_gap2", 64'(g_cyc[2] - g_cyc[1]), 64'd2);
            chk("t3_gap3", 64'(g_cyc[3] - g_cyc[2]), 64'd2);
        end

        // T4: outstanding limit for m1
        do_reset();
        m_arvalid = 3'b010; s_arready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_arready[1]) cnt++;
            step();
        end
        chk("t4_grants", 64'(cnt), 64'd2);
        @(negedge clk);
        chk("t4_held", 64'(m_arready), 64'd0);
        step();
        s_rvalid = 1'b1; s_rid = 4'd1; s_rlast = 1'b1; m_rready = 3'b010;
        @(negedge clk);
        chk("t4_rready", 64'(s_rready), 64'd1);
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        chk("t4_regrant", 64'(m_arready), 64'b010);

        // T5: unknown RID is drained and flagged once
        do_reset();
        s_rvalid = 1'b1; s_rid = 4'd5; m_rready = 3'b000;
        @(negedge clk);
        chk("t5_rready", 64'(s_rready), 64'd1);
        chk("t5_mrvalid", 64'(m_rvalid), 64'd0);
        chk("t5_err_pre", 64'(err_unk_id), 64'd0);
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 64'(err_unk_id), 64'd1);
        step();
        @(negedge clk);
        chk("t5_err_clear", 64'(err_unk_id), 64'd0);

        // T6: async reset while AR pending
        do_reset();
        m_arvalid = 3'b011; s_arready = 1'b0;
        step();
        @(negedge clk);
        chk("t6_pending", 64'(s_arvalid), 64'd1);
        chk("t6_arid", 64'(s_arid), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 64'(s_arvalid), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_m0_first", 64'(m_arready), 64'b001);

        // Randomized run against a behavioural model
        do_reset();
        md_busy = 0; md_last = 2; md_err = 0; md_id = 0; md_addr = '0; md_len = '0;
        for (int i = 0; i < 3; i++) md_outst[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            int w, rid;
            bit found, exp_srr, hs;
            logic [2:0] exp_rdy, exp_mrv;
            m_arvalid = 3'($urandom);
            m_araddr  = {$urandom, $urandom, $urandom};
            m_arlen   = 12'($urandom);
            s_arready = ($urandom_range(0, 2) != 0);
            s_rvalid  = ($urandom_range(0, 1) != 0);
            s_rid     = 4'($urandom_range(0, 4));
            s_rlast   = ($urandom_range(0, 2) == 0);
            m_rready  = 3'($urandom);
            @(negedge clk);
            rid = int'(s_rid);
            found = 0; w = 0; exp_rdy = '0;
            if (!md_busy) begin
                for (int k = 1; k <= 3; k++) begin
                    int idx;
                    idx = (md_last + k) % 3;
                    if (!found && m_arvalid[idx] && md_outst[idx] < 2) begin
                        found = 1; w = idx;
                    end
                end
                if (found) exp_rdy[w] = 1'b1;
            end
            exp_srr = (rid < 3) ? m_rready[rid] : 1'b1;
            exp_mrv = (s_rvalid && rid < 3) ? 3'(1 << rid) : 3'b000;
            chk("rnd_arready", 64'(m_arready), 64'(exp_rdy));
            chk("rnd_arvalid", 64'(s_arvalid), 64'(md_busy));
            chk("rnd_mrvalid", 64'(m_rvalid), 64'(exp_mrv));
            chk("rnd_srready", 64'(s_rready), 64'(exp_srr));
            chk("rnd_err", 64'(err_unk_id), 64'(md_err));
            if (md_busy) begin
                chk("rnd_arid", 64'(s_arid), 64'(md_id));
                chk("rnd_araddr", 64'(s_araddr), 64'(md_addr));
                chk("rnd_arlen", 64'(s_arlen), 64'(md_len));
            end
            hs = s_rvalid && exp_srr;
            md_err = hs && (rid >= 3);
            if (hs && s_rlast && rid < 3 && md_outst[rid] > 0) md_outst[rid]--;
            if (md_busy) begin
                if (s_arready) begin
                    md_outst[md_id]++;
                    md_busy = 0;
                end
            end else if (found) begin
                md_busy = 1; md_id = w; md_last = w;
                md_addr = m_araddr[w*32 +: 32];
                md_len  = m_arlen[w*4 +: 4];
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
